// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V fetch constants and types
// Purpose: constants and types shared by the fetch stage and its users.
// Ports: none (package).
package riscv_pkg;

  localparam int RV_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes, handy for decoding id_instr when debugging.
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [31:0]        instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched (pc, instr) entries
// Purpose: DEPTH-entry buffer between instruction memory and decode.
// Ports: clk/reset (async, active-high); push/push_data write an entry;
//        pop retires the head; flush empties the queue (wins over push/pop);
//        count/empty report occupancy; head is the oldest entry.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset; count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction-fetch stage
// Purpose: owns the fetch PC, issues sequential requests to instruction
//          memory, buffers in-order responses and feeds decode; a redirect
//          flushes the queue and discards stale in-flight responses.
// Ports: clk, reset (async, active-high);
//        redirect_valid/redirect_pc   - EX branch/jump target (single cycle);
//        imem_req_valid/ready/addr    - request channel to instruction memory;
//        imem_rsp_valid/data          - in-order responses, no backpressure;
//        id_valid/id_ready/id_pc/id_instr - handshake to decode.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    fpc;
  logic [XLEN-1:0]    rpc;
  logic [XLEN-1:0]    target;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      drop;
  logic [CW-1:0]      live;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic               q_empty;
  logic [XLEN+31:0]   q_head;
  logic               accept;
  logic               push;
  logic               pop;

  assign target = redirect_pc & ~XLEN'(3);
  assign live   = inflight - drop;
  assign pop    = id_valid & id_ready;

  // Credit: every live request already owns a queue slot, so the queue can
  // never be pushed while full. The pop term lets a consumed slot be reused
  // in the same cycle, which is what sustains one fetch per cycle.
  assign occupancy = {1'b0, count} + {1'b0, live} - (CW+1)'(pop);

  // Stale responses still occupy inflight after a redirect; refusing to
  // issue at the counter's ceiling keeps it from wrapping under a slow
  // memory with repeated redirects. Once asserted, valid stays up because
  // inflight can only grow through an acceptance.
  assign imem_req_valid = !reset && !redirect_valid &&
                          (occupancy < (CW+1)'(DEPTH)) && (inflight != '1);
  assign imem_req_addr  = fpc;
  assign accept         = imem_req_valid & imem_req_ready;

  // A response is kept only if no older redirect has marked it stale.
  assign push = imem_rsp_valid & !redirect_valid & (drop == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding is stale; a response arriving in this
      // very cycle has already returned and is simply ignored.
      fpc      <= target;
      rpc      <= target;
      inflight <= inflight - CW'(imem_rsp_valid);
      drop     <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (accept) fpc <= fpc + XLEN'(4);
      if (push)   rpc <= rpc + XLEN'(4);
      if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({rpc, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign id_valid = !q_empty && !redirect_valid;
  assign id_pc    = q_empty ? '0 : q_head[XLEN+31:32];
  assign id_instr = q_empty ? NOP_INSTR : q_head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: accepted requests answered in order after lat cycles.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;

  // Stimulus knobs for the next cycle.
  logic        drv_req_ready = 1'b1;
  logic        drv_id_ready  = 1'b1;
  logic        drv_redirect  = 1'b0;
  logic [31:0] drv_redirect_pc = '0;

  // Reference model: decode must see consecutive PCs from the last
  // redirect/reset with the memory's data; fetches follow the same rule.
  logic [31:0] exp_pc    = '0;
  logic [31:0] exp_fetch = '0;
  int          useful    = 0;   // accepted since redirect minus consumed
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  int          id_fires   = 0;

  // Values sampled in the most recent cycle.
  logic        s_req_valid, s_req_fire, s_rsp, s_id_valid, s_id_fire;
  logic [31:0] s_addr, s_id_pc, s_id_instr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, advance model
  // after the posedge.
  task automatic step();
    int nxt;
    @(negedge clk);
    imem_req_ready = drv_req_ready;
    id_ready       = drv_id_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_fn(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_fire  = imem_req_valid & imem_req_ready;
    s_addr      = imem_req_addr;
    s_rsp       = imem_rsp_valid;
    s_id_valid  = id_valid;
    s_id_fire   = id_valid & id_ready;
    s_id_pc     = id_pc;
    s_id_instr  = id_instr;
    if (!reset) begin
      if (redirect_valid) begin
        checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_quiet: id_valid=%b req_valid=%b, required 0/0", s_id_valid, s_req_valid);
        end
      end else if (prev_stall) begin
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_hold: valid=%b addr=%h, required 1/%h", s_req_valid, s_addr, prev_addr);
        end
      end
      if (s_req_fire) begin
        checks++;
        if (s_addr !== exp_fetch) begin
          errors++;
          $display("FAIL fetch_addr: got %h, required %h", s_addr, exp_fetch);
        end
      end
      if (s_id_fire) begin
        checks++;
        if (s_id_pc !== exp_pc || s_id_instr !== mem_fn(exp_pc)) begin
          errors++;
          $display("FAIL id_stream: pc=%h instr=%h, required pc=%h instr=%h", s_id_pc, s_id_instr, exp_pc, mem_fn(exp_pc));
        end
      end
      nxt = useful + (s_req_fire ? 1 : 0) - (s_id_fire ? 1 : 0);
      checks++;
      if (nxt > DEPTH) begin
        errors++;
        $display("FAIL credit: outstanding %0d, required <= %0d", nxt, DEPTH);
      end
    end
    @(posedge clk);
    if (reset) begin
      mq.delete();
      exp_pc = 32'h0; exp_fetch = 32'h0; useful = 0; prev_stall = 1'b0;
    end else begin
      if (s_rsp) void'(mq.pop_front());
      if (redirect_valid) begin
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        exp_fetch = exp_pc;
        useful    = 0;
      end else begin
        if (s_req_fire) begin
          mq.push_back('{addr: s_addr, due: cyc + lat});
          exp_fetch = exp_fetch + 32'd4;
        end
        if (s_id_fire) begin
          exp_pc = exp_pc + 32'd4;
          id_fires++;
        end
        useful = useful + (s_req_fire ? 1 : 0) - (s_id_fire ? 1 : 0);
      end
      prev_stall = s_req_valid & ~imem_req_ready & ~redirect_valid;
      prev_addr  = s_addr;
    end
    cyc++;
  endtask

  task automatic do_reset();
    drv_req_ready = 1'b1; drv_id_ready = 1'b1; drv_redirect = 1'b0; lat = 1;
    reset = 1'b1;
    step();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req_valid=%b id_valid=%b instr=%h pc=%h, required 0/0/%h/0", imem_req_valid, id_valid, id_instr, id_pc, NOP_INSTR);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (s_req_fire !== 1'b1 || s_addr !== 32'h0) begin
          errors++;
          $display("FAIL first_request: fire=%b addr=%h, required 1/00000000", s_req_fire, s_addr);
        end
      end
      checks++;
      if (s_id_valid !== (k >= 3)) begin
        errors++;
        $display("FAIL stream_valid: cycle %0d id_valid=%b, required %b", k, s_id_valid, (k >= 3));
      end
    end
  endtask

  task automatic test_backpressure();
    drv_id_ready = 1'b0;
    repeat (10) step();
    checks++;
    if (useful != DEPTH || s_req_valid !== 1'b0 || s_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_fill: buffered=%0d req_valid=%b id_valid=%b, required %0d/0/1", useful, s_req_valid, s_id_valid, DEPTH);
    end
    drv_id_ready = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_req_stall();
    logic [31:0] held;
    drv_req_ready = 1'b0;
    step();
    held = s_addr;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_addr !== held) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%h, required 1/%h", s_req_valid, s_addr, held);
      end
    end
    drv_req_ready = 1'b1;
    step();
    checks++;
    if (s_req_fire !== 1'b1 || s_addr !== held) begin
      errors++;
      $display("FAIL stall_release: fire=%b addr=%h, required 1/%h", s_req_fire, s_addr, held);
    end
    repeat (8) step();
  endtask

  task automatic test_redirect_inflight();
    bit found = 0;
    do_reset();
    lat = 2;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (mq.size() == 2 && mq[0].addr == 32'h10 && mq[1].addr == 32'h14) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL inflight_setup: never saw 0x10/0x14 outstanding, required within 30 cycles");
    end
    drv_redirect = 1'b1; drv_redirect_pc = 32'h200;
    step();
    drv_redirect = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (s_id_valid !== 1'b0 || s_req_fire !== 1'b1 || s_addr !== 32'h200) begin
          errors++;
          $display("FAIL redirect_t1: id_valid=%b fire=%b addr=%h, required 0/1/00000200", s_id_valid, s_req_fire, s_addr);
        end
      end
      checks++;
      if (s_id_valid !== (k == 4) || (k == 4 && s_id_pc !== 32'h200)) begin
        errors++;
        $display("FAIL redirect_id: T+%0d id_valid=%b pc=%h, required %b/00000200", k, s_id_valid, s_id_pc, (k == 4));
      end
    end
    repeat (6) step();
  endtask

  task automatic test_redirect_with_rsp();
    bit found = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mq.size() == 1 && mq[0].addr == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rsp_setup: 0x8 never outstanding, required within 20 cycles");
    end
    drv_redirect = 1'b1; drv_redirect_pc = 32'h103;
    step();
    drv_redirect = 1'b0;
    checks++;
    if (s_rsp !== 1'b1) begin
      errors++;
      $display("FAIL rsp_collide: response in redirect cycle=%b, required 1", s_rsp);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (s_req_fire !== 1'b1 || s_addr !== 32'h100) begin
          errors++;
          $display("FAIL aligned_fetch: fire=%b addr=%h, required 1/00000100", s_req_fire, s_addr);
        end
      end
      checks++;
      if (s_id_valid !== (k == 3) || (k == 3 && (s_id_pc !== 32'h100 || s_id_instr !== mem_fn(32'h100)))) begin
        errors++;
        $display("FAIL aligned_id: T+%0d id_valid=%b pc=%h, required %b/00000100", k, s_id_valid, s_id_pc, (k == 3));
      end
    end
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    drv_id_ready = 1'b0;
    repeat (6) step();
    checks++;
    if (s_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL premid_state: id_valid=%b, required 1", s_id_valid);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req_valid=%b id_valid=%b instr=%h pc=%h, required 0/0/%h/0", imem_req_valid, id_valid, id_instr, id_pc, NOP_INSTR);
    end
    drv_id_ready = 1'b1;
    step();
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (s_req_fire !== 1'b1 || s_addr !== 32'h0) begin
          errors++;
          $display("FAIL refetch: fire=%b addr=%h, required 1/00000000", s_req_fire, s_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
          errors++;
          $display("FAIL refetch_id: id_valid=%b pc=%h, required 1/00000000", s_id_valid, s_id_pc);
        end
      end
    end
  endtask

  task automatic test_random();
    int start_fires;
    do_reset();
    start_fires = id_fires;
    for (int i = 0; i < 400; i++) begin
      drv_id_ready    = ($urandom_range(0, 3) != 0);
      drv_req_ready   = ($urandom_range(0, 2) != 0);
      lat             = $urandom_range(1, 3);
      drv_redirect    = ($urandom_range(0, 24) == 0);
      drv_redirect_pc = $urandom & 32'h0000_FFFF;
      step();
    end
    drv_redirect = 1'b0;
    checks++;
    if (id_fires - start_fires < 50) begin
      errors++;
      $display("FAIL random_progress: %0d instructions consumed, required >= 50", id_fires - start_fires);
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
